tsn_packet_action_mport: RTL



---
 rtl/tsn_pkt_action_pkg.sv | 40 ++++
 rtl/tsn_packet_action_mport_fifo.sv | 67 ++++++
 rtl/tsn_packet_action_mport.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tsn_pkt_action_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tsn_pkt_action_pkg : descriptor types, defaults and popcount helper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tsn_pkt_action_pkg;

  localparam int DFLT_PORT_NUM   = 8;
  localparam int DFLT_BUFID_W    = 9;
  localparam int DFLT_TYPE_W     = 3;
  localparam int DFLT_SUBMIT_W   = 5;
  localparam int DFLT_INPORT_W   = 4;
  localparam int DFLT_FIFO_DEPTH = 4;

  // Bitmap position of the host destination for the default port count.
  localparam int HOST_BIT = DFLT_PORT_NUM;

  typedef struct packed {
    logic [DFLT_BUFID_W-1:0] bufid;
    logic [DFLT_TYPE_W-1:0]  ptype;
  } port_entry_t;

  typedef struct packed {
    logic [DFLT_BUFID_W-1:0]  bufid;
    logic [DFLT_TYPE_W-1:0]   ptype;
    logic [DFLT_SUBMIT_W-1:0] submit_addr;
    logic [DFLT_INPORT_W-1:0] inport;
  } host_entry_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tsn_packet_action_mport_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tpa_desc_fifo : synchronous descriptor FIFO with occupancy count     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tpa_desc_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  // Raw head; the consumer gates it to zero while empty.
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tsn_packet_action_mport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tsn_packet_action_mport : replicate descriptors into port/host FIFOs |
// | Optional stats counters: TSN_PKT_ACTION_STATS_EN.  Revision: 1.0     |
// +----------------------------------------------------------------------+
module tsn_packet_action_mport
  import tsn_pkt_action_pkg::*;
#(
  parameter int PORT_NUM   = DFLT_PORT_NUM,
  parameter int BUFID_W    = DFLT_BUFID_W,
  parameter int TYPE_W     = DFLT_TYPE_W,
  parameter int SUBMIT_W   = DFLT_SUBMIT_W,
  parameter int INPORT_W   = DFLT_INPORT_W,
  parameter int FIFO_DEPTH = DFLT_FIFO_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PORT_NUM:0]            iv_outport,
  input  logic                         i_outport_wr,
  input  logic [PORT_NUM:0]            iv_ram_rdata,
  input  logic [BUFID_W-1:0]           iv_pkt_bufid,
  input  logic [TYPE_W-1:0]            iv_pkt_type,
  input  logic [SUBMIT_W-1:0]          iv_submit_addr,
  input  logic [INPORT_W-1:0]          iv_inport,
  input  logic                         i_pkt_bufid_wr,
  output logic                         o_pkt_bufid_rdy,
  output logic [PORT_NUM*BUFID_W-1:0]  ov_pkt_bufid_port,
  output logic [PORT_NUM*TYPE_W-1:0]   ov_pkt_type_port,
  output logic [PORT_NUM-1:0]          ov_pkt_bufid_wr_port,
  input  logic [PORT_NUM-1:0]          iv_port_rdy,
  output logic [BUFID_W-1:0]           ov_pkt_bufid_host,
  output logic [TYPE_W-1:0]            ov_pkt_type_host,
  output logic [SUBMIT_W-1:0]          ov_submit_addr_host,
  output logic [INPORT_W-1:0]          ov_inport_host,
  output logic                         o_pkt_bufid_wr_host,
  input  logic                         i_host_rdy,
  output logic [BUFID_W-1:0]           ov_pkt_bufid,
  output logic                         o_pkt_bufid_wr,
  output logic [$clog2(PORT_NUM+2)-1:0] ov_pkt_bufid_cnt
`ifdef TSN_PKT_ACTION_STATS_EN
  ,
  output logic [PORT_NUM*32-1:0]       ov_port_fwd_cnt,
  output logic [31:0]                  ov_host_fwd_cnt,
  output logic [31:0]                  ov_stall_cnt
`endif
);

  localparam int c_CNT_W    = $clog2(PORT_NUM + 2);
  localparam int c_PE_W     = BUFID_W + TYPE_W;
  localparam int c_HE_W     = c_PE_W + SUBMIT_W + INPORT_W;
  localparam int c_OCC_W    = $clog2(FIFO_DEPTH + 1);
  localparam int c_HOST_BIT = PORT_NUM;
  localparam logic [PORT_NUM:0] c_HOST_ONLY = {1'b1, {PORT_NUM{1'b0}}};

  logic [PORT_NUM:0]  w_mask_raw;
  logic [PORT_NUM:0]  w_mask;
  logic [PORT_NUM:0]  w_push;
  logic [PORT_NUM:0]  w_pop;
  logic [PORT_NUM:0]  w_full;
  logic [PORT_NUM:0]  w_empty;
  logic [PORT_NUM:0]  w_valid;
  logic               w_accept;
  logic [63:0]        w_mask64;
  int unsigned        w_dests;
  logic               r_bufid_wr;
  logic [BUFID_W-1:0] r_bufid;
  logic [c_CNT_W-1:0] r_cnt;

  assign w_mask_raw      = i_outport_wr ? iv_outport : iv_ram_rdata;
  // An empty destination set would leak the buffer; send it to the host.
  assign w_mask          = (w_mask_raw == '0) ? c_HOST_ONLY : w_mask_raw;
  assign o_pkt_bufid_rdy = ~|w_full;
  assign w_accept        = i_pkt_bufid_wr & o_pkt_bufid_rdy;
  assign w_push          = {(PORT_NUM + 1){w_accept}} & w_mask;
  assign w_mask64        = 64'(w_mask);
  assign w_dests         = popcount(w_mask64);

  for (genvar k = 0; k <= PORT_NUM; k++) begin : g_fifo
    if (k == c_HOST_BIT) begin : g_host
      logic [c_HE_W-1:0]  w_din;
      logic [c_HE_W-1:0]  w_dout;
      logic [c_OCC_W-1:0] w_occ;
      assign w_din      = {iv_pkt_bufid, iv_pkt_type, iv_submit_addr, iv_inport};
      assign w_valid[k] = (w_occ != '0);
      assign w_pop[k]   = w_valid[k] & i_host_rdy;
      assign {ov_pkt_bufid_host, ov_pkt_type_host, ov_submit_addr_host, ov_inport_host} =
        w_empty[k] ? '0 : w_dout;
      tpa_desc_fifo #(.WIDTH(c_HE_W), .DEPTH(FIFO_DEPTH), .CNT_W(c_OCC_W)) u_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_push[k]), .i_din(w_din),
        .i_pop(w_pop[k]), .o_dout(w_dout), .o_full(w_full[k]),
        .o_empty(w_empty[k]), .o_count(w_occ)
      );
    end else begin : g_port
      logic [c_PE_W-1:0]  w_din;
      logic [c_PE_W-1:0]  w_dout;
      logic [c_OCC_W-1:0] w_occ;
      assign w_din      = {iv_pkt_bufid, iv_pkt_type};
      assign w_valid[k] = (w_occ != '0);
      assign w_pop[k]   = w_valid[k] & iv_port_rdy[k];
      assign ov_pkt_bufid_wr_port[k] = w_valid[k];
      assign {ov_pkt_bufid_port[k*BUFID_W +: BUFID_W], ov_pkt_type_port[k*TYPE_W +: TYPE_W]} =
        w_empty[k] ? '0 : w_dout;
      tpa_desc_fifo #(.WIDTH(c_PE_W), .DEPTH(FIFO_DEPTH), .CNT_W(c_OCC_W)) u_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_push[k]), .i_din(w_din),
        .i_pop(w_pop[k]), .o_dout(w_dout), .o_full(w_full[k]),
        .o_empty(w_empty[k]), .o_count(w_occ)
      );
    end
  end

  assign o_pkt_bufid_wr_host = w_valid[c_HOST_BIT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bufid_wr <= 1'b0;
      r_bufid    <= '0;
      r_cnt      <= '0;
    end else begin
      r_bufid_wr <= w_accept;
      if (w_accept) begin
        r_bufid <= iv_pkt_bufid;
        r_cnt   <= c_CNT_W'(w_dests);
      end
    end
  end

  assign o_pkt_bufid_wr   = r_bufid_wr;
  assign ov_pkt_bufid     = r_bufid;
  assign ov_pkt_bufid_cnt = r_cnt;

`ifdef TSN_PKT_ACTION_STATS_EN
  logic [31:0] r_stall_cnt;

  for (genvar k = 0; k <= PORT_NUM; k++) begin : g_stats
    logic [31:0] r_fwd_cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_fwd_cnt <= '0;
      end else if (w_pop[k] && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + 1'b1;
      end
    end
    if (k == c_HOST_BIT) begin : g_host_cnt
      assign ov_host_fwd_cnt = r_fwd_cnt;
    end else begin : g_port_cnt
      assign ov_port_fwd_cnt[k*32 +: 32] = r_fwd_cnt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (i_pkt_bufid_wr && !o_pkt_bufid_rdy && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ov_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
